alu_pipe: RTL and testbench

//   Parametrised, two-stage pipelined ALU with valid/ready handshakes on input and output.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core.sv | 53 +++++
 rtl/alu_pipe.sv | 120 ++++++++++++
 tb/tb_alu_pipe.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and shared constants for the pipelined ALU
package alu_pkg;
  localparam int OP_W = 4;
  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EQ   = 4'd15
  } alu_op_e;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath between the two pipeline stages
// ALU_FLAGS_EN adds the signed-overflow output for ADD/SUB.
import alu_pkg::*;
module alu_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
`ifdef ALU_FLAGS_EN
  ,
  output logic             ovf_o
`endif
);
  localparam int SH_W = $clog2(WIDTH);
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;
  logic [SH_W-1:0]      sh;
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
  assign sh   = b_i[SH_W-1:0];
  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD:  {carry_o, result_o} = sum;
      OP_SUB:  begin result_o = a_i - b_i; carry_o = a_i < b_i; end
      OP_MUL:  begin result_o = prod[WIDTH-1:0]; carry_o = |prod[2*WIDTH-1:WIDTH]; end
      OP_DIV:  begin result_o = (b_i == '0) ? '1 : a_i / b_i; carry_o = b_i == '0; end
      OP_SHL:  result_o = a_i << sh;
      OP_SHR:  result_o = a_i >> sh;
      OP_ROL:  result_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
      OP_ROR:  result_o = {a_i[0], a_i[WIDTH-1:1]};
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_NAND: result_o = ~(a_i & b_i);
      OP_XNOR: result_o = ~(a_i ^ b_i);
      OP_GT:   result_o = {{(WIDTH-1){1'b0}}, a_i > b_i};
      OP_EQ:   result_o = {{(WIDTH-1){1'b0}}, a_i == b_i};
      default: ;
    endcase
  end
`ifdef ALU_FLAGS_EN
  // overflow when operand signs make the result sign impossible
  assign ovf_o = (op_i == OP_ADD) ? ~(a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (result_o[WIDTH-1] ^ a_i[WIDTH-1])
               : (op_i == OP_SUB) ? (a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (result_o[WIDTH-1] ^ a_i[WIDTH-1])
               : 1'b0;
`endif
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ALU with tag passthrough and completed-op counter
// ALU_FLAGS_EN adds registered out_zero/out_neg/out_ovf outputs.
import alu_pkg::*;
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
`ifdef ALU_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
`endif
);
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, core_res;
  logic [OP_W-1:0]  op_q, op_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d;
  logic             carry_q, carry_d, core_carry;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_adv, acc, ld2;
`ifdef ALU_FLAGS_EN
  logic zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d, core_ovf;
`endif
  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (core_res),
    .carry_o  (core_carry)
`ifdef ALU_FLAGS_EN
    ,
    .ovf_o    (core_ovf)
`endif
  );
  // stage 1 moves whenever stage 2 is empty or draining this cycle
  assign s1_adv = !s2_valid_q | out_ready;
  assign in_ready = !s1_valid_q | s1_adv;
  assign acc = in_valid & in_ready;
  assign ld2 = s1_adv & s1_valid_q;
  always_comb begin
    s1_valid_d = acc | (s1_valid_q & !s1_adv);
    a_d        = acc ? in_a : a_q;
    b_d        = acc ? in_b : b_q;
    op_d       = acc ? in_op : op_q;
    tag1_d     = acc ? in_tag : tag1_q;
    s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
    res_d      = ld2 ? core_res : res_q;
    carry_d    = ld2 ? core_carry : carry_q;
    tag2_d     = ld2 ? tag1_q : tag2_q;
    cnt_d      = (s2_valid_q & out_ready) ? cnt_q + CNT_W'(1) : cnt_q;
`ifdef ALU_FLAGS_EN
    zero_d     = ld2 ? (core_res == '0) : zero_q;
    neg_d      = ld2 ? core_res[WIDTH-1] : neg_q;
    ovf_d      = ld2 ? core_ovf : ovf_q;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tag1_q     <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      tag2_q     <= '0;
      cnt_q      <= '0;
`ifdef ALU_FLAGS_EN
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tag1_q     <= tag1_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      tag2_q     <= tag2_d;
      cnt_q      <= cnt_d;
`ifdef ALU_FLAGS_EN
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
`endif
    end
  end
  assign out_valid  = s2_valid_q;
  assign out_result = res_q;
  assign out_carry  = carry_q;
  assign out_tag    = tag2_q;
  assign busy       = s1_valid_q | s2_valid_q;
  assign op_count   = cnt_q;
`ifdef ALU_FLAGS_EN
  assign out_zero = zero_q;
  assign out_neg  = neg_q;
  assign out_ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe (WIDTH=8); checks flags when ALU_FLAGS_EN is defined
module tb_alu_pipe;
  import alu_pkg::*;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0;
  logic [3:0]  in_op = '0, in_tag = '0;
  logic        in_ready, out_valid, out_carry, busy;
  logic [7:0]  out_result;
  logic [3:0]  out_tag;
  logic [15:0] op_count;
`ifdef ALU_FLAGS_EN
  logic        out_zero, out_neg, out_ovf;
`endif
  int checks = 0, failures = 0, exp_cnt = 0, cyc;
  logic [3:0] op_v [16], tag_v [16];
  logic [7:0] a_v [16], b_v [16], res_v [16];
  logic       car_v [16], ovf_v [16];
  logic [7:0] sres [16] = '{8'h9D, 8'h97, 8'hCE, 8'h33, 8'hD0, 8'h13, 8'h35, 8'h4D,
                            8'h02, 8'h9B, 8'h99, 8'h64, 8'hFD, 8'h66, 8'h01, 8'h00};
  alu_pipe #(.WIDTH(8), .TAG_W(4), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_tag    (out_tag),
    .busy       (busy),
    .op_count   (op_count)
`ifdef ALU_FLAGS_EN
    ,
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_ovf    (out_ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic set_vec(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] tag, input logic [7:0] res, input logic car);
    op_v[i] = op; a_v[i] = a; b_v[i] = b; tag_v[i] = tag; res_v[i] = res; car_v[i] = car; ovf_v[i] = 1'b0;
  endtask
  // offers n ops, holds out_ready low for the first hold cycles, checks outputs in order
  task automatic run_ops(input int n, input int hold, output int cycles);
    int sent, got;
    logic acc;
    sent = 0; got = 0; cycles = 0;
    while (got < n && cycles < 100) begin
      @(negedge clk);
      out_ready = (cycles >= hold);
      if (hold > 0 && (cycles == 2 || cycles == hold - 1)) begin
        check("stall_valid", out_valid, 1);
        check("stall_res", out_result, res_v[0]);
        check("stall_tag", out_tag, tag_v[0]);
      end
      if (hold > 0 && cycles == hold - 1) begin
        check("stall_accepted", sent, 2);
        check("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        check($sformatf("res%0d", got), out_result, res_v[got]);
        check($sformatf("carry%0d", got), out_carry, car_v[got]);
        check($sformatf("tag%0d", got), out_tag, tag_v[got]);
`ifdef ALU_FLAGS_EN
        check($sformatf("zero%0d", got), out_zero, res_v[got] == 8'h00);
        check($sformatf("neg%0d", got), out_neg, res_v[got][7]);
        check($sformatf("ovf%0d", got), out_ovf, ovf_v[got]);
`endif
        got++;
      end
      in_valid = sent < n;
      if (sent < n) begin
        in_a = a_v[sent]; in_b = b_v[sent]; in_op = op_v[sent]; in_tag = tag_v[sent];
      end
      acc = in_valid & in_ready;
      @(posedge clk);
      if (acc) sent++;
      cycles++;
    end
    in_valid = 1'b0;
    check("delivered", got, n);
    exp_cnt += n;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_result", {out_carry, out_tag, out_result}, 0);
    reset = 1'b0;
    set_vec(0, OP_ADD, 8'hFF, 8'h01, 4'd3, 8'h00, 1'b1);
    run_ops(1, 0, cyc);
    check("add_latency", cyc, 3);
    set_vec(0, OP_SUB, 8'h05, 8'h07, 4'd1, 8'hFE, 1'b1);
    run_ops(1, 0, cyc);
    set_vec(0, OP_DIV, 8'h10, 8'h00, 4'd2, 8'hFF, 1'b1);
    run_ops(1, 0, cyc);
    set_vec(0, OP_MUL, 8'h10, 8'h10, 4'd4, 8'h00, 1'b1);
    run_ops(1, 0, cyc);
`ifdef ALU_FLAGS_EN
    set_vec(0, OP_ADD, 8'h7F, 8'h01, 4'd9, 8'h80, 1'b0);
    ovf_v[0] = 1'b1;
    run_ops(1, 0, cyc);
`endif
    @(negedge clk);
    check("count_singles", op_count, exp_cnt);
    for (int i = 0; i < 16; i++) set_vec(i, 4'(i), 8'h9A, 8'h03, 4'(i), sres[i], i == 2);
    run_ops(16, 0, cyc);
    check("stream_cycles", cyc, 18);
    @(negedge clk);
    check("count_stream", op_count, exp_cnt);
    set_vec(0, OP_ADD, 8'h10, 8'h20, 4'd5, 8'h30, 1'b0);
    set_vec(1, OP_XOR, 8'hF0, 8'h0F, 4'd6, 8'hFF, 1'b0);
    set_vec(2, OP_OR, 8'h01, 8'h02, 4'd7, 8'h03, 1'b0);
    run_ops(3, 5, cyc);
    @(negedge clk);
    check("count_stall", op_count, exp_cnt);
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h01; in_b = 8'h01; in_op = OP_ADD; in_tag = 4'd1;
    @(posedge clk);
    @(negedge clk);
    in_tag = 4'd2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("full_busy", busy, 1);
    check("full_in_ready", in_ready, 0);
    #2 reset = 1'b1;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_busy", busy, 0);
    check("async_op_count", op_count, 0);
    check("async_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    exp_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_valid", out_valid, 0);
    end
    set_vec(0, OP_NAND, 8'hF0, 8'h3C, 4'd8, 8'hCF, 1'b0);
    run_ops(1, 0, cyc);
    @(negedge clk);
    check("count_after_rst", op_count, exp_cnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
